// File: rtl/event_pkg.sv
// event_queue shared definitions
// Event codes and widths used by the queue and its level filters.
package event_pkg;

    localparam int EV_W   = 4;
    localparam int NUM_EV = 14;

    localparam logic [EV_W-1:0] EV_NONE       = 4'd0;
    localparam logic [EV_W-1:0] EV_GO         = 4'd1;
    localparam logic [EV_W-1:0] EV_AWAKE      = 4'd2;
    localparam logic [EV_W-1:0] EV_PRESS      = 4'd3;
    localparam logic [EV_W-1:0] EV_UP         = 4'd4;
    localparam logic [EV_W-1:0] EV_DOWN       = 4'd5;
    localparam logic [EV_W-1:0] EV_LEFT       = 4'd6;
    localparam logic [EV_W-1:0] EV_RIGHT      = 4'd7;
    localparam logic [EV_W-1:0] EV_TOUCH_ON   = 4'd8;
    localparam logic [EV_W-1:0] EV_TOUCH_OFF  = 4'd9;
    localparam logic [EV_W-1:0] EV_EXPECT_ON  = 4'd10;
    localparam logic [EV_W-1:0] EV_EXPECT_OFF = 4'd11;
    localparam logic [EV_W-1:0] EV_PET_ON     = 4'd12;
    localparam logic [EV_W-1:0] EV_PET_OFF    = 4'd13;

    // Number of level sensors; level k owns codes 8+2k (ON) and 9+2k (OFF).
    localparam int NUM_LVL = 3;

    // Saturating add of a small increment onto a CNT_W-bit counter.
    function automatic longint sat_add(longint cur, int inc, int width);
        longint max_v;
        longint sum;
        max_v = (longint'(1) << width) - 1;
        sum   = cur + longint'(inc);
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/event_queue_level_filter.sv
// event_queue level filter
// Synchronises an async level and debounces it with a stable counter.
module level_filter
    import event_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic filtered,
    output logic rise_req,
    output logic fall_req
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;
    logic          r_rise;
    logic          r_fall;

    // Sync the level, count disagreement, flip and pulse a request when stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= lvl;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
                r_rise <= r_sync2;
                r_fall <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign filtered = r_filt;
    assign rise_req = r_rise;
    assign fall_req = r_fall;

endmodule

// File: rtl/event_queue.sv
// event_queue top
// Merges sensor pulses and debounced levels into one FIFO of event codes.
module event_queue
    import event_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int CNT_W         = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         go,
    input  logic                         awaking,
    input  logic                         pressed,
    input  logic                         up,
    input  logic                         down,
    input  logic                         left,
    input  logic                         right,
    input  logic                         touched,
    input  logic                         expecting,
    input  logic                         petting,
    input  logic                         ev_ready,
    output logic                         ev_valid,
    output logic [EV_W-1:0]              ev_code,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_W-1:0]             coalesce_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [EV_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [LW-1:0]     r_cnt;
    logic [NUM_EV-1:0] r_pend;
    logic [CNT_W-1:0]  r_coal;

    logic [NUM_LVL-1:0] w_lvl_in;
    logic [NUM_LVL-1:0] w_filt;
    logic [NUM_LVL-1:0] w_rise;
    logic [NUM_LVL-1:0] w_fall;
    logic [NUM_LVL-1:0] w_on;
    logic [NUM_LVL-1:0] w_off;

    logic [NUM_EV-1:0] w_pulse;
    logic [NUM_EV-1:0] w_clr;
    logic [NUM_EV-1:0] w_pend_nxt;
    logic [EV_W-1:0]   w_sel;
    logic              w_any;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    int                w_nmerge;
    logic [CNT_W-1:0]  w_coal_nxt;

    assign w_lvl_in = {petting, expecting, touched};

    for (genvar k = 0; k < NUM_LVL; k++) begin : g_lvl
        level_filter #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_filt (
            .clk      (clk),
            .rst      (rst),
            .lvl      (w_lvl_in[k]),
            .filtered (w_filt[k]),
            .rise_req (w_rise[k]),
            .fall_req (w_fall[k])
        );
    end

    // A request is only honoured when the filter agrees with its direction.
    assign w_on  = w_rise & w_filt;
    assign w_off = w_fall & ~w_filt;

    // Map pulse inputs onto their code positions.
    always_comb begin
        w_pulse           = '0;
        w_pulse[EV_GO]    = go;
        w_pulse[EV_AWAKE] = awaking;
        w_pulse[EV_PRESS] = pressed;
        w_pulse[EV_UP]    = up;
        w_pulse[EV_DOWN]  = down;
        w_pulse[EV_LEFT]  = left;
        w_pulse[EV_RIGHT] = right;
    end

    // Pick the lowest-numbered pending code and decide whether it moves.
    always_comb begin
        w_sel = EV_NONE;
        w_any = 1'b0;
        for (int i = NUM_EV - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel = EV_W'(i);
                w_any = 1'b1;
            end
        end
        w_full = (r_cnt == FULL);
        w_pop  = ev_valid & ev_ready;
        w_push = w_any & (~w_full | w_pop);
        w_clr  = '0;
        if (w_push) begin
            w_clr[w_sel] = 1'b1;
        end
    end

    // Next pending set: drain, new pulses, level requests and merge count.
    always_comb begin
        w_pend_nxt = (r_pend & ~w_clr) | (w_pulse & ~r_pend);
        w_nmerge   = 0;
        for (int i = 0; i < NUM_EV; i++) begin
            if (w_pulse[i] && r_pend[i]) begin
                w_nmerge = w_nmerge + 1;
            end
        end
        for (int k = 0; k < NUM_LVL; k++) begin
            // An opposite code still waiting cancels out; one leaving now does not.
            if (w_on[k]) begin
                if (r_pend[int'(EV_TOUCH_OFF) + 2*k] &&
                    !w_clr[int'(EV_TOUCH_OFF) + 2*k]) begin
                    w_pend_nxt[int'(EV_TOUCH_OFF) + 2*k] = 1'b0;
                end else begin
                    w_pend_nxt[int'(EV_TOUCH_ON) + 2*k] = 1'b1;
                end
            end
            if (w_off[k]) begin
                if (r_pend[int'(EV_TOUCH_ON) + 2*k] &&
                    !w_clr[int'(EV_TOUCH_ON) + 2*k]) begin
                    w_pend_nxt[int'(EV_TOUCH_ON) + 2*k] = 1'b0;
                end else begin
                    w_pend_nxt[int'(EV_TOUCH_OFF) + 2*k] = 1'b1;
                end
            end
        end
        w_coal_nxt = CNT_W'(sat_add(longint'(r_coal), w_nmerge, CNT_W));
    end

    // FIFO storage, pointers, occupancy, pending set and coalesce counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_pend <= '0;
            r_coal <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_coal <= w_coal_nxt;
            if (w_push) begin
                r_mem[r_wp] <= w_sel;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign ev_valid     = (r_cnt != '0);
    assign ev_code      = ev_valid ? r_mem[r_rp] : EV_NONE;
    assign fifo_level   = r_cnt;
    assign coalesce_cnt = r_coal;

endmodule

// File: tb/tb_event_queue.sv
// event_queue bench
// Directed scenarios with hand-computed expected codes and levels.
module tb_event_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0, awaking = 1'b0, pressed = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       touched = 1'b0, expecting = 1'b0, petting = 1'b0;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [3:0] ev_code;
    logic [2:0] fifo_level;
    logic [7:0] coalesce_cnt;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int got[$];
    int got_t[$];

    event_queue #(
        .DEPTH         (4),
        .STABLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .awaking      (awaking),
        .pressed      (pressed),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .touched      (touched),
        .expecting    (expecting),
        .petting      (petting),
        .ev_ready     (ev_ready),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .fifo_level   (fifo_level),
        .coalesce_cnt (coalesce_cnt)
    );

    always #5 clk = ~clk;

    // Record every accepted code, sampled away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst && ev_valid && ev_ready) begin
            got.push_back(int'(ev_code));
            got_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int code);
        case (code)
            1: go      = 1'b1;
            2: awaking = 1'b1;
            3: pressed = 1'b1;
            4: up      = 1'b1;
            5: down    = 1'b1;
            6: left    = 1'b1;
            7: right   = 1'b1;
            default: ;
        endcase
        tick();
        {go, awaking, pressed, up, down, left, right} = '0;
    endtask

    function automatic int count_of(input int c);
        int n = 0;
        foreach (got[i]) if (got[i] == c) n++;
        return n;
    endfunction

    initial begin
        int seq3[6];
        int seq4[5];
        seq3 = '{1, 2, 3, 4, 5, 6};
        seq4 = '{1, 2, 3, 5, 4};

        // Reset values
        tick(2);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_code", int'(ev_code), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_coal", int'(coalesce_cnt), 0);
        rst = 1'b1;
        tick(2);

        // 1: single pulse latency
        ev_ready = 1'b1;
        got.delete(); got_t.delete();
        pulse(4);
        check("t1_valid_n1", int'(ev_valid), 0);
        tick();
        check("t1_valid_n2", int'(ev_valid), 1);
        check("t1_code_n2", int'(ev_code), 4);
        tick();
        check("t1_valid_n3", int'(ev_valid), 0);
        check("t1_level_n3", int'(fifo_level), 0);
        check("t1_count", got.size(), 1);

        // 2: simultaneous pulses
        got.delete(); got_t.delete();
        go = 1'b1; left = 1'b1; right = 1'b1;
        tick();
        {go, left, right} = '0;
        tick(6);
        check("t2_count", got.size(), 3);
        if (got.size() == 3) begin
            check("t2_c0", got[0], 1);
            check("t2_c1", got[1], 6);
            check("t2_c2", got[2], 7);
            check("t2_gap01", got_t[1] - got_t[0], 1);
            check("t2_gap12", got_t[2] - got_t[1], 1);
        end
        check("t2_coal", int'(coalesce_cnt), 0);

        // 3: back-pressure with two pending beyond a full FIFO
        ev_ready = 1'b0;
        got.delete(); got_t.delete();
        for (int c = 1; c <= 6; c++) pulse(c);
        tick(3);
        check("t3_level_full", int'(fifo_level), 4);
        check("t3_head", int'(ev_code), 1);
        ev_ready = 1'b1;
        tick(12);
        check("t3_count", got.size(), 6);
        if (got.size() == 6) begin
            foreach (seq3[i]) check($sformatf("t3_c%0d", i), got[i], seq3[i]);
        end
        check("t3_level_empty", int'(fifo_level), 0);

        // 4: coalescing while full
        ev_ready = 1'b0;
        got.delete(); got_t.delete();
        pulse(1); pulse(2); pulse(3); pulse(5);
        tick(3);
        check("t4_level_full", int'(fifo_level), 4);
        pulse(4);
        pulse(4);
        tick(2);
        check("t4_coal", int'(coalesce_cnt), 1);
        check("t4_level_hold", int'(fifo_level), 4);
        ev_ready = 1'b1;
        tick(12);
        check("t4_count", got.size(), 5);
        if (got.size() == 5) begin
            foreach (seq4[i]) check($sformatf("t4_c%0d", i), got[i], seq4[i]);
        end
        check("t4_up_once", count_of(4), 1);

        // 5: level filter
        got.delete(); got_t.delete();
        touched = 1'b1;
        tick(3);
        touched = 1'b0;
        tick(12);
        check("t5_glitch", got.size(), 0);
        touched = 1'b1;
        tick(12);
        tick(4);
        check("t5_on_count", got.size(), 1);
        if (got.size() == 1) check("t5_on_code", got[0], 8);
        touched = 1'b0;
        tick(12);
        tick(4);
        check("t5_off_count", got.size(), 2);
        if (got.size() == 2) check("t5_off_code", got[1], 9);

        // 6: ON cancelled by OFF while full, then reset mid-operation
        ev_ready = 1'b0;
        got.delete(); got_t.delete();
        pulse(1); pulse(2); pulse(3); pulse(4);
        tick(3);
        touched = 1'b1;
        tick(10);
        check("t6_level_full", int'(fifo_level), 4);
        touched = 1'b0;
        tick(12);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        tick(3);
        check("t6_level_after_pop", int'(fifo_level), 3);
        check("t6_head", int'(ev_code), 2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_rst_valid", int'(ev_valid), 0);
        check("t6_rst_level", int'(fifo_level), 0);
        check("t6_rst_code", int'(ev_code), 0);
        ev_ready = 1'b1;
        tick(20);
        check("t6_no_touch", count_of(8) + count_of(9), 0);
        check("t6_count", got.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
